// File: rtl/ac_stack.sv
// ---------------------------------------------------------------------------
// ac_stack: accumulator register with a LIFO save stack.
//
// The accumulator sits between the ALU result and the bus. An opcode-driven
// set of operations (load/clear/inc/dec/push/pop/swap) updates it. A small
// stack holds saved accumulator values for context save/restore.
//
// Ports:
//   clk          system clock; every state update happens on its rising edge
//   reset        synchronous, active-low reset
//   write_en     strobe; op executes only when 1
//   op[2:0]      operation select (see op_e)
//   AC_in        ALU result, used as the LOAD source
//   ALU          accumulator value, feeds the ALU operand input
//   bus_out      accumulator value, feeds the bus (same as ALU)
//   Zflag        acc == 0 or acc is negative (legacy "<= 0" test)
//   Eflag        acc == 0 exactly
//   Nflag        acc sign bit
//   stack_full   stack holds stack_depth entries
//   stack_empty  stack holds no entries
//   err          sticky: a push to a full stack, or a pop/swap on an empty one
// ---------------------------------------------------------------------------
module ac_stack #(
   parameter int reg_width   = 12,
   parameter int stack_depth = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write_en,
   input  logic [2:0]           op,
   input  logic [reg_width-1:0] AC_in,
   output logic [reg_width-1:0] ALU,
   output logic [reg_width-1:0] bus_out,
   output logic                 Zflag,
   output logic                 Eflag,
   output logic                 Nflag,
   output logic                 stack_full,
   output logic                 stack_empty,
   output logic                 err
);

   localparam int cnt_w = $clog2(stack_depth + 1);
   localparam int idx_w = (stack_depth > 1) ? $clog2(stack_depth) : 1;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_LOAD  = 3'b001,
      OP_CLEAR = 3'b010,
      OP_INC   = 3'b011,
      OP_DEC   = 3'b100,
      OP_PUSH  = 3'b101,
      OP_POP   = 3'b110,
      OP_SWAP  = 3'b111
   } op_e;

   logic [reg_width-1:0] acc;
   logic [cnt_w-1:0]     count;
   logic [reg_width-1:0] stack_mem [stack_depth];

   logic [reg_width-1:0] acc_nxt;
   logic [cnt_w-1:0]     count_nxt;
   logic                 err_nxt;
   logic                 flags_upd;
   logic                 mem_we;
   logic [idx_w-1:0]     mem_idx;
   logic [idx_w-1:0]     top_idx;
   logic                 full;
   logic                 empty;

   assign full    = (count == cnt_w'(stack_depth));
   assign empty   = (count == '0);
   assign top_idx = idx_w'(count - cnt_w'(1));

   // NOTE: every signal written here gets a default first so no latch is
   // inferred on paths where an op leaves it untouched.
   always_comb begin
      acc_nxt   = acc;
      count_nxt = count;
      err_nxt   = err;
      flags_upd = 1'b0;
      mem_we    = 1'b0;
      mem_idx   = top_idx;
      if (write_en) begin
         unique case (op_e'(op))
            OP_NOP: ;
            OP_LOAD: begin
               acc_nxt   = AC_in;
               flags_upd = 1'b1;
            end
            OP_CLEAR: begin
               acc_nxt   = '0;
               flags_upd = 1'b1;
            end
            OP_INC: begin
               acc_nxt   = acc + reg_width'(1);
               flags_upd = 1'b1;
            end
            OP_DEC: begin
               acc_nxt   = acc - reg_width'(1);
               flags_upd = 1'b1;
            end
            OP_PUSH: begin
               if (full) begin
                  err_nxt = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_idx   = idx_w'(count);
                  count_nxt = count + cnt_w'(1);
                  flags_upd = 1'b1;
               end
            end
            OP_POP: begin
               if (empty) begin
                  err_nxt = 1'b1;
               end else begin
                  acc_nxt   = stack_mem[top_idx];
                  count_nxt = count - cnt_w'(1);
                  flags_upd = 1'b1;
               end
            end
            OP_SWAP: begin
               // The top entry is read and overwritten on the same edge; the
               // read sees the pre-edge value, so old acc and top trade places.
               if (empty) begin
                  err_nxt = 1'b1;
               end else begin
                  acc_nxt   = stack_mem[top_idx];
                  mem_we    = 1'b1;
                  flags_upd = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc   <= '0;
         count <= '0;
         err   <= 1'b0;
         Zflag <= 1'b0;
         Eflag <= 1'b0;
         Nflag <= 1'b0;
      end else begin
         acc   <= acc_nxt;
         count <= count_nxt;
         err   <= err_nxt;
         if (flags_upd) begin
            Eflag <= (acc_nxt == '0);
            Nflag <= acc_nxt[reg_width-1];
            Zflag <= (acc_nxt == '0) || acc_nxt[reg_width-1];
         end
      end
   end

   // NOTE: stack storage has no reset; clearing count is enough to discard
   // its contents, and leaving it unreset lets it map onto plain RAM/regs.
   always_ff @(posedge clk) begin
      if (reset && mem_we) begin
         stack_mem[mem_idx] <= acc;
      end
   end

   assign ALU         = acc;
   assign bus_out     = acc;
   assign stack_full  = full;
   assign stack_empty = empty;

endmodule
